// File: rtl/lsu_wb_master_pkg.sv
// Shared encodings for the LSU Wishbone master: access sizes, FSM states and
// the alignment rule used to reject an access before any bus cycle starts.
package lsu_wb_master_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    STROBE   = 2'b01,
    WAIT_ACK = 2'b10,
    RESP     = 2'b11
  } lsu_state_e;

  // Size 11 is illegal and is reported the same way as a misaligned access.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_wb_master_align.sv
// Combinational lane logic shared by bus masters: byte-enable generation,
// store-data replication and load-data extraction with sign/zero extension.
module lsu_align
  import lsu_wb_master_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted_s;

  assign shifted_s = rdata_raw_i >> {addr_lo_i, 3'b000};

  // Lane selection, store replication and load extension per access size.
  always_comb begin
    sel_o   = 4'b0000;
    wdata_o = 32'h0000_0000;
    rdata_o = 32'h0000_0000;
    case (size_i)
      SZ_BYTE: begin
        sel_o   = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h00_0000, shifted_s[7:0]}
                             : {{24{shifted_s[7]}}, shifted_s[7:0]};
      end
      SZ_HALF: begin
        sel_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'h0000, shifted_s[15:0]}
                             : {{16{shifted_s[15]}}, shifted_s[15:0]};
      end
      SZ_WORD: begin
        sel_o   = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted_s;
      end
      default: begin
        sel_o   = 4'b0000;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// Single-outstanding load/store unit master on a pipelined Wishbone bus.
// Define LSU_WB_TIMEOUT_EN to abort an unanswered bus cycle after TIMEOUT_CYCLES.
module lsu_wb_master
  import lsu_wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i
);

  lsu_state_e  state_q;
  logic        ready_q, cyc_q, stb_q, we_q;
  logic [31:0] adr_q, dat_q, rdata_q;
  logic [3:0]  sel_q;
  logic        resp_valid_q, resp_err_q;
  logic [1:0]  size_q, addr_lo_q;
  logic        uns_q;

  logic [1:0]  al_size_s, al_addr_lo_s;
  logic [3:0]  al_sel_s;
  logic [31:0] al_wdata_s, al_rdata_s;
  logic        bus_done_s;

`ifdef LSU_WB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit_s;
  assign tmo_hit_s = (tmo_q == TMO_LAST);
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES == 0);
`endif

  assign bus_done_s = wb_ack_i | wb_err_i;

  // The aligner sees the live request while idle and the latched one afterwards.
  always_comb begin
    if (state_q == IDLE) begin
      al_size_s    = req_size_i;
      al_addr_lo_s = req_addr_i[1:0];
    end else begin
      al_size_s    = size_q;
      al_addr_lo_s = addr_lo_q;
    end
  end

  lsu_align u_align (
    .size_i      (al_size_s),
    .addr_lo_i   (al_addr_lo_s),
    .unsigned_i  (uns_q),
    .wdata_i     (req_wdata_i),
    .rdata_raw_i (wb_dat_i),
    .sel_o       (al_sel_s),
    .wdata_o     (al_wdata_s),
    .rdata_o     (al_rdata_s)
  );

  // Transaction FSM; every bus and response output is a register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 32'h0000_0000;
      dat_q        <= 32'h0000_0000;
      sel_q        <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      size_q       <= 2'b00;
      addr_lo_q    <= 2'b00;
      uns_q        <= 1'b0;
`ifdef LSU_WB_TIMEOUT_EN
      tmo_q        <= {TMO_W{1'b0}};
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            ready_q   <= 1'b0;
            we_q      <= req_we_i;
            adr_q     <= {req_addr_i[31:2], 2'b00};
            sel_q     <= al_sel_s;
            dat_q     <= al_wdata_s;
            size_q    <= req_size_i;
            addr_lo_q <= req_addr_i[1:0];
            uns_q     <= req_unsigned_i;
            if (lsu_misaligned(req_size_i, req_addr_i[1:0])) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              rdata_q      <= 32'h0000_0000;
            end else begin
              state_q <= STROBE;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
`ifdef LSU_WB_TIMEOUT_EN
              tmo_q   <= {TMO_W{1'b0}};
`endif
            end
          end
        end
        STROBE, WAIT_ACK: begin
`ifdef LSU_WB_TIMEOUT_EN
          tmo_q <= tmo_q + 1'b1;
`endif
          // Error wins over ack; stores and errors always return zero data.
          if (bus_done_s) begin
            state_q      <= RESP;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= wb_err_i;
            rdata_q      <= (wb_err_i || we_q) ? 32'h0000_0000 : al_rdata_s;
          end
`ifdef LSU_WB_TIMEOUT_EN
          else if (tmo_hit_s) begin
            state_q      <= RESP;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            rdata_q      <= 32'h0000_0000;
          end
`endif
          else if ((state_q == STROBE) && !wb_stall_i) begin
            state_q <= WAIT_ACK;
            stb_q   <= 1'b0;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          ready_q    <= 1'b1;
          resp_err_q <= 1'b0;
          rdata_q    <= 32'h0000_0000;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = rdata_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Self-checking bench for lsu_wb_master against a registered-ack memory slave.
module tb_lsu_wb_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  logic        resp_valid_o, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i, wb_ack_i, wb_err_i;
  logic [31:0] wb_dat_i;

  int errors = 0;
  int checks = 0;

  int stall_cnt = 0;
  bit never_ack = 1'b0;
  bit slave_err = 1'b0;
  logic [31:0] mem [0:255];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        bus;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[17];

  always #5 wb_clk_i = ~wb_clk_i;

  assign wb_stall_i = (stall_cnt != 0);

  lsu_wb_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel_o),
    .wb_stall_i     (wb_stall_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i),
    .wb_dat_i       (wb_dat_i)
  );

  // Memory slave: takes a strobe that is not stalled and acks on the next cycle.
  initial begin
    bit          take, dec;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        s_we;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
    forever begin
      @(negedge wb_clk_i);
      take  = wb_cyc_o && wb_stb_o && (stall_cnt == 0);
      dec   = wb_cyc_o && wb_stb_o && (stall_cnt != 0);
      s_adr = wb_adr_o;
      s_dat = wb_dat_o;
      s_sel = wb_sel_o;
      s_we  = wb_we_o;
      @(posedge wb_clk_i);
      #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (dec) stall_cnt = stall_cnt - 1;
      if (take && !never_ack) begin
        if (slave_err) begin
          wb_err_i = 1'b1;
          wb_dat_i = 32'hBAD0_BAD0;
        end else begin
          if (s_we) begin
            for (int b = 0; b < 4; b++)
              if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] = s_dat[8*b +: 8];
            wb_dat_i = 32'h0;
          end else begin
            wb_dat_i = mem[s_adr[9:2]];
          end
          wb_ack_i = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, watch the bus, and score the response against the queue.
  task automatic do_req(input vec_t v, input int exp_lat, input int exp_stb, input string tag);
    int          n;
    int          stb_cnt;
    bit          saw_cyc, adr_bad, sel_done, got;
    exp_t        e;
    logic [31:0] exp_adr;
    exp_adr = {v.addr[31:2], 2'b00};
    @(negedge wb_clk_i);
    req_valid_i    = 1'b1;
    req_we_i       = v.we;
    req_addr_i     = v.addr;
    req_wdata_i    = v.wdata;
    req_size_i     = v.size;
    req_unsigned_i = v.uns;
    n = 0;
    while (!req_ready_o && n < 10) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (!req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL %s ready: got 0, want 1", tag);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge wb_clk_i);
    sb_q.push_back('{rdata: v.rdata, err: v.err});
    #1 req_valid_i = 1'b0;
    n = 0; stb_cnt = 0; saw_cyc = 1'b0; adr_bad = 1'b0; sel_done = 1'b0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge wb_clk_i);
      n++;
      if (wb_stb_o) begin
        stb_cnt++;
        if (!sel_done) begin
          sel_done = 1'b1;
          check({tag, " sel"}, {28'h0, wb_sel_o}, {28'h0, v.sel});
          if (v.we) check({tag, " dat_o"}, wb_dat_o, v.dat);
        end
      end
      if (wb_cyc_o) begin
        saw_cyc = 1'b1;
        if (wb_adr_o !== exp_adr || wb_we_o !== v.we) adr_bad = 1'b1;
      end
      if (resp_valid_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s resp: no response within 40 cycles", tag);
      void'(sb_q.pop_front());
      return;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    e = sb_q.pop_front();
    check({tag, " rdata"}, resp_rdata_o, e.rdata);
    check({tag, " err"}, {31'h0, resp_err_o}, {31'h0, e.err});
    if (v.bus) begin
      check({tag, " stb cycles"}, 32'(stb_cnt), 32'(exp_stb));
      check({tag, " adr/we stable"}, {31'h0, adr_bad}, 32'h0);
    end else begin
      check({tag, " no cyc"}, {31'h0, saw_cyc}, 32'h0);
    end
    @(negedge wb_clk_i);
    check({tag, " pulse"}, {31'h0, resp_valid_o}, 32'h0);
  endtask

  initial begin
    int n;
    bit seen;
    vec_t sv;
    //         we    addr          wdata         size   uns   bus   sel      dat           rdata         err
    vecs[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 1'b1, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h103, 32'h12345680, 2'b00, 1'b0, 1'b1, 4'b1000, 32'h80808080, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h103, 32'h0,        2'b00, 1'b0, 1'b1, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 32'h103, 32'h0,        2'b00, 1'b1, 1'b1, 4'b1000, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 32'h101, 32'h0,        2'b00, 1'b0, 1'b1, 4'b0010, 32'h0,        32'hFFFFFFBE, 1'b0};
    vecs[6]  = '{1'b1, 32'h200, 32'h80011234, 2'b10, 1'b0, 1'b1, 4'b1111, 32'h80011234, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h202, 32'h0,        2'b01, 1'b0, 1'b1, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[8]  = '{1'b0, 32'h200, 32'h0,        2'b01, 1'b1, 1'b1, 4'b0011, 32'h0,        32'h00001234, 1'b0};
    vecs[9]  = '{1'b1, 32'h202, 32'hFFFF7E5A, 2'b01, 1'b0, 1'b1, 4'b1100, 32'h7E5A7E5A, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h200, 32'h0,        2'b10, 1'b0, 1'b1, 4'b1111, 32'h0,        32'h7E5A1234, 1'b0};
    vecs[11] = '{1'b0, 32'h101, 32'h0,        2'b10, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h203, 32'h0,        2'b01, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'h200, 32'h0,        2'b11, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, 32'h102, 32'hFFFFFFFF, 2'b10, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[15] = '{1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 1'b1, 4'b1111, 32'h0,        32'h80ADBEEF, 1'b0};
    vecs[16] = '{1'b0, 32'h200, 32'h0,        2'b00, 1'b1, 1'b1, 4'b0001, 32'h0,        32'h00000034, 1'b0};

    wb_rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'h0;
    req_wdata_i = 32'h0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("reset ready", {31'h0, req_ready_o}, 32'h1);
    check("reset cyc/stb/we", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
    check("reset resp", {30'h0, resp_valid_o, resp_err_o}, 32'h0);
    check("reset rdata", resp_rdata_o, 32'h0);
    check("reset adr", wb_adr_o, 32'h0);
    check("reset sel", {28'h0, wb_sel_o}, 32'h0);
    wb_rst_i = 1'b0;

    for (int i = 0; i < 17; i++)
      do_req(vecs[i], vecs[i].bus ? 3 : 1, 1, $sformatf("vec%0d", i));

    // Slave stalls three cycles, then answers with an error.
    sv = '{1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1};
    stall_cnt = 3;
    slave_err = 1'b1;
    do_req(sv, 6, 4, "stall_err");
    slave_err = 1'b0;
    stall_cnt = 0;

`ifdef LSU_WB_TIMEOUT_EN
    never_ack = 1'b1;
    sv = '{1'b0, 32'h104, 32'h0, 2'b10, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1};
    do_req(sv, 9, 1, "timeout");
    never_ack = 1'b0;
`endif

    // Reset while waiting for an ack that never comes.
    never_ack = 1'b1;
    @(negedge wb_clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h100;
    req_size_i = 2'b10; req_unsigned_i = 1'b0;
    @(posedge wb_clk_i);
    #1 req_valid_i = 1'b0;
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!(wb_cyc_o && !wb_stb_o) && n < 10);
    check("rst wait_ack reached", {31'h0, wb_cyc_o & ~wb_stb_o}, 32'h1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rst cyc/stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
    check("rst ready", {31'h0, req_ready_o}, 32'h1);
    wb_rst_i = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge wb_clk_i);
      if (resp_valid_o) seen = 1'b1;
    end
    check("rst no resp", {31'h0, seen}, 32'h0);
    never_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
